param_sequence_detector: RTL and testbench

PARAM_SEQUENCE_DETECTOR -- requirements
Module: param_sequence_detector

---
 rtl/param_sequence_detector.sv | 90 +++++++++
 tb/tb_param_sequence_detector.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/param_sequence_detector.sv
// Runtime-configurable serial pattern detector with overlap control
// and a saturating match counter.
module param_sequence_detector #(
  parameter int                 MAX_LEN     = 8,
  parameter int                 CNT_W       = 8,
  parameter logic [MAX_LEN-1:0] DEF_PATTERN = MAX_LEN'(8'b0000_1011),
  parameter int                 DEF_LEN     = 4,
  parameter bit                 DEF_OVERLAP = 1'b1,
  parameter int                 LEN_W       = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               in,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] pattern,
  input  logic [LEN_W-1:0]   len,
  input  logic               overlap,
  output logic               out,
  output logic [LEN_W-1:0]   state,
  output logic [CNT_W-1:0]   match_count
);

  logic [MAX_LEN-1:0] pat_q;
  logic [LEN_W-1:0]   len_q;
  logic               ovl_q;

  logic [LEN_W-1:0]   eff_len;
  logic [LEN_W-1:0]   nk;
  logic [LEN_W-1:0]   nxt;
  logic [MAX_LEN-1:0] pfx;
  logic [MAX_LEN:0]   tail;
  logic               hit;
  logic               ok;

  assign eff_len = (len_q > LEN_W'(MAX_LEN)) ?
                   LEN_W'(MAX_LEN) : len_q;

  // pfx[MAX_LEN-1-j] is the j-th expected bit
  assign pfx  = pat_q << (LEN_W'(MAX_LEN) - eff_len);

  // tail[0] is the new bit, tail[m] the bit m steps older
  assign tail = {pfx >> (LEN_W'(MAX_LEN) - state), in};

  assign hit = (eff_len != '0) &&
               (state == eff_len - LEN_W'(1)) &&
               (in == pat_q[0]);

  assign out = hit && en && !cfg_load && !rst;

  // Longest proper prefix that is a suffix of history + in
  always_comb begin
    nk = '0;
    ok = 1'b0;
    for (int k = 1; k < MAX_LEN; k++) begin
      ok = (LEN_W'(k) < eff_len) &&
           ((LEN_W+1)'(k) <=
            ({1'b0, state} + (LEN_W+1)'(1)));
      for (int j = 0; j < k; j++) begin
        if (tail[k-1-j] != pfx[MAX_LEN-1-j])
          ok = 1'b0;
      end
      if (ok)
        nk = LEN_W'(k);
    end
  end

  assign nxt = (hit && !ovl_q) ? '0 : nk;

  always_ff @(posedge clk) begin
    if (rst) begin
      pat_q       <= DEF_PATTERN;
      len_q       <= LEN_W'(DEF_LEN);
      ovl_q       <= DEF_OVERLAP;
      state       <= '0;
      match_count <= '0;
    end else if (cfg_load) begin
      pat_q       <= pattern;
      len_q       <= len;
      ovl_q       <= overlap;
      state       <= '0;
      match_count <= '0;
    end else if (en) begin
      state <= nxt;
      if (hit && (match_count != '1))
        match_count <= match_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_param_sequence_detector.sv
// Scoreboard bench for param_sequence_detector using a brute-force
// history model; a second instance has a 2-bit counter.
module tb_param_sequence_detector;

  logic       clk = 1'b0;
  logic       rst, en, in, cfg_load, overlap;
  logic [7:0] pattern;
  logic [3:0] len;
  logic       out, out2;
  logic [3:0] state, state2;
  logic [7:0] match_count;
  logic [1:0] match_count2;

  always #5 clk = ~clk;

  param_sequence_detector dut (
    .clk(clk), .rst(rst), .en(en), .in(in),
    .cfg_load(cfg_load), .pattern(pattern), .len(len),
    .overlap(overlap), .out(out), .state(state),
    .match_count(match_count)
  );

  param_sequence_detector #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .en(en), .in(in),
    .cfg_load(cfg_load), .pattern(pattern), .len(len),
    .overlap(overlap), .out(out2), .state(state2),
    .match_count(match_count2)
  );

  typedef struct {
    bit o;
    int st;
    int cnt;
    int cnt2;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;

  bit [7:0] mp;
  int       ml;
  bit       mov;
  bit       hist[$];
  int       mcnt, mcnt2;

  task automatic check(string tag, logic [31:0] got,
                       logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d t=%0t",
               tag, got, exp, $time);
    end
  endtask

  function automatic int model_len();
    return (ml > 8) ? 8 : ml;
  endfunction

  function automatic int model_state();
    int L, best, n;
    bit ok;
    L = model_len();
    best = 0;
    n = hist.size();
    for (int k = 1; k < L; k++) begin
      if (k <= n) begin
        ok = 1'b1;
        for (int j = 0; j < k; j++)
          if (hist[n-k+j] != mp[L-1-j]) ok = 1'b0;
        if (ok) best = k;
      end
    end
    return best;
  endfunction

  task automatic cyc(bit r, bit c, bit e, bit i);
    exp_t x;
    exp_t y;
    int   L, n;
    bit   m;
    logic obs, obs2;
    rst = r; cfg_load = c; en = e; in = i;
    x.o = 1'b0;
    if (r) begin
      mp = 8'b0000_1011; ml = 4; mov = 1'b1;
      hist.delete(); mcnt = 0; mcnt2 = 0;
    end else if (c) begin
      mp = pattern; ml = int'(len); mov = overlap;
      hist.delete(); mcnt = 0; mcnt2 = 0;
    end else if (e) begin
      L = model_len();
      if (L == 0) begin
        hist.delete();
      end else begin
        hist.push_back(i);
        if (hist.size() > 16) void'(hist.pop_front());
        n = hist.size();
        m = (n >= L);
        for (int j = 0; j < L; j++)
          if (m && hist[n-1-j] != mp[j]) m = 1'b0;
        if (m) begin
          x.o = 1'b1;
          if (mcnt < 255) mcnt++;
          if (mcnt2 < 3) mcnt2++;
          if (!mov) hist.delete();
        end
      end
    end
    x.st = model_state();
    x.cnt = mcnt;
    x.cnt2 = mcnt2;
    sb.push_back(x);
    @(negedge clk);
    obs = out;
    obs2 = out2;
    @(posedge clk);
    #1;
    y = sb.pop_front();
    check("out", 32'(obs), 32'(y.o));
    check("out2", 32'(obs2), 32'(y.o));
    check("state", 32'(state), 32'(y.st));
    check("count", 32'(match_count), 32'(y.cnt));
    check("count2", 32'(match_count2), 32'(y.cnt2));
  endtask

  task automatic feed(bit [15:0] bits, int n);
    for (int k = n - 1; k >= 0; k--)
      cyc(1'b0, 1'b0, 1'b1, bits[k]);
  endtask

  task automatic cfg(bit [7:0] p, bit [3:0] l, bit o);
    pattern = p; len = l; overlap = o;
    cyc(1'b0, 1'b1, 1'b1, 1'b1);
    pattern = 8'($urandom);
    len = 4'($urandom);
    overlap = 1'($urandom);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; en = 1'b0; in = 1'b0; cfg_load = 1'b0;
    pattern = 8'h00; len = 4'd0; overlap = 1'b0;
    cyc(1'b1, 1'b0, 1'b1, 1'b1);
    cyc(1'b1, 1'b1, 1'b1, 1'b1);

    pattern = 8'hFF; len = 4'd2;
    feed(16'b101_1011, 7);
    check("req031_count", 32'(match_count), 32'd2);

    cfg(8'b1011, 4'd4, 1'b0);
    feed(16'b101_1011, 7);
    check("req032_count", 32'(match_count), 32'd1);

    cfg(8'b111, 4'd3, 1'b1);
    feed(16'b11_1111, 6);
    cfg(8'b111, 4'd3, 1'b0);
    feed(16'b11_1111, 6);

    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'($urandom));
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'($urandom));
    cyc(1'b0, 1'b0, 1'b1, 1'b1);
    cyc(1'b0, 1'b0, 1'b1, 1'b1);

    cfg(8'b1, 4'd1, 1'b1);
    feed(16'b1_1111, 5);
    check("req035_sat", 32'(match_count2), 32'd3);

    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    feed(16'b101, 3);
    cyc(1'b1, 1'b0, 1'b1, 1'b1);
    feed(16'b1, 1);

    cfg(8'b1011, 4'd0, 1'b1);
    feed(16'b1011_1011, 8);
    cfg(8'b1100_1010, 4'd12, 1'b1);
    feed(16'b1100_1010_1100_1010, 16);
    cfg(8'hF5, 4'd3, 1'b1);
    feed(16'b1010_1101_0101_0110, 16);

    for (int blk = 0; blk < 24; blk++) begin
      cfg(8'($urandom),
          4'($urandom_range(blk % 6 == 0 ? 0 : 1, 5)),
          1'($urandom));
      for (int b = 0; b < 30; b++)
        cyc(($urandom_range(0, 99) < 2),
            1'b0,
            ($urandom_range(0, 9) != 0),
            1'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
